// File: rtl/muldiv_wb_arbiter.sv
// Writeback arbiter for the mult functional unit.
// Merges single-stage multiplier results and serial divider results into one
// registered writeback port. Multiplier results cannot be stalled, so they go
// through an in-order skid FIFO and issue is throttled by a credit signal.
// Divider results are back-pressured through a valid/ready handshake.
module muldiv_wb_arbiter #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i,
  input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
  output logic                     issue_ready_o,
  input  logic                     div_valid_i,
  input  logic [XLEN-1:0]          div_result_i,
  input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
  output logic                     div_ready_o,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  input  logic                     wb_ready_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]          mem_result [DEPTH];
  logic [TRANS_ID_BITS-1:0] mem_id     [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;

  logic             load_en;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             bypass;
  logic             div_take;
  logic             push_ok;
  logic             active;
  logic [CNT_W:0]   credit_sum;

  // Source selection and handshakes; flush and reset suppress every transfer.
  always_comb begin
    active     = ~rst_i & ~flush_i;
    load_en    = ~wb_valid_o | wb_ready_i;
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_W'(DEPTH));
    pop        = active & load_en & ~fifo_empty;
    bypass     = active & load_en & fifo_empty & mul_valid_i;
    div_take   = active & load_en & fifo_empty & ~mul_valid_i & div_valid_i;
    // A non-bypassed multiplier beat is pushed; on overflow it is dropped.
    push_ok    = active & mul_valid_i & ~bypass & (~fifo_full | pop);
    credit_sum = {1'b0, count} + (CNT_W+1)'(mul_valid_i);
    // Registered count only: a drain this cycle is deliberately not credited.
    issue_ready_o = ~rst_i & (credit_sum <= (CNT_W+1)'(DEPTH - 1));
    // During flush the divider is drained so its discarded result clears out.
    div_ready_o   = ~rst_i & (flush_i | (load_en & fifo_empty & ~mul_valid_i));
  end

  // Output register, FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_valid_o    <= 1'b0;
      wb_result_o   <= '0;
      wb_trans_id_o <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else if (flush_i) begin
      // Data/id deliberately hold their old values across a flush.
      wb_valid_o <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (load_en) begin
        if (pop) begin
          wb_valid_o    <= 1'b1;
          wb_result_o   <= mem_result[rd_ptr];
          wb_trans_id_o <= mem_id[rd_ptr];
        end else if (bypass) begin
          wb_valid_o    <= 1'b1;
          wb_result_o   <= mul_result_i;
          wb_trans_id_o <= mul_trans_id_i;
        end else if (div_take) begin
          wb_valid_o    <= 1'b1;
          wb_result_o   <= div_result_i;
          wb_trans_id_o <= div_trans_id_i;
        end else begin
          wb_valid_o <= 1'b0;
        end
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_result[wr_ptr] <= mul_result_i;
      mem_id[wr_ptr]     <= mul_trans_id_i;
    end
  end

  // A multiplier beat arriving with a full FIFO and no drain is a protocol error.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(mul_valid_i && fifo_full && !pop));

endmodule
